sort_wave_scheduler: RTL and testbench

- Collects per-port write requests into one-entry holding registers and issues them as a "wave" into the `odd_even_sort` network.
- Waits the sorter's fixed pipeline latency, then resolves destination conflicts in the sorted result: one winner per destination, losers retried in the next wave.
- Presents the conflict-free wave downstream with a valid/ready handshake.
- Sits between the input ports and the sorter/shared-memory write path.

---
 rtl/sort_wave_scheduler_if.sv | 28 ++
 rtl/sort_wave_scheduler.sv | 144 ++++++++++++++
 tb/tb_sort_wave_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_wave_scheduler_if.sv
// Request and result handshake bundle for sort_wave_scheduler.
// master: requesters + downstream consumer; slave: the scheduler.
interface sort_wave_scheduler_if #(
    parameter int PORT_NUB = 4,
    parameter int AW       = 2,
    parameter int DW       = 8
);
    localparam int WT = PORT_NUB * (1 + 2 * AW + DW);

    logic [PORT_NUB-1:0]    req_valid;
    logic [PORT_NUB-1:0]    req_ready;
    logic [PORT_NUB*AW-1:0] req_dest;
    logic [PORT_NUB*DW-1:0] req_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WT-1:0]          out_port;
    logic [PORT_NUB-1:0]    grant;

    modport master (
        output req_valid, req_dest, req_data, out_ready,
        input  req_ready, out_valid, out_port, grant
    );

    modport slave (
        input  req_valid, req_dest, req_data, out_ready,
        output req_ready, out_valid, out_port, grant
    );
endinterface

// File: rtl/sort_wave_scheduler.sv
// Batches per-port requests into sorter waves, resolves dest conflicts
// (one winner per dest, losers retried) and hands the wave downstream.
// Ports: clk, rst (sync, active-high), bus (req_*/out_*/grant, slave),
//   sort_in/sort_out to the odd_even_sort network, busy (FSM not IDLE).
// Option: define SORT_SCHED_BATCH_EN for batch-fair request gating.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module sort_wave_scheduler #(
    parameter int  PORT_NUB = 4,
    parameter int  SORT_LAT = 3,
    localparam int AW       = $clog2(`PORT_NUB_TOTAL),
    localparam int DW       = `DATA_WIDTH,
    localparam int WP       = 1 + 2 * AW + DW,
    localparam int WT       = PORT_NUB * WP
) (
    input  logic                 clk,
    input  logic                 rst,
    sort_wave_scheduler_if.slave bus,
    output logic [WT-1:0]        sort_in,
    input  logic [WT-1:0]        sort_out,
    output logic                 busy
);
    localparam int CW = $clog2(SORT_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [PORT_NUB-1:0] hold_v;
    logic [AW-1:0]       hold_dest [PORT_NUB];
    logic [DW-1:0]       hold_data [PORT_NUB];
    logic [PORT_NUB-1:0] accept;
    logic [PORT_NUB-1:0] win_src;
    logic [WT-1:0]       resolved;
    logic [WT-1:0]       wave;
    logic                capture;

`ifdef SORT_SCHED_BATCH_EN
    logic batch_open;

    // Reopens only once every hold has drained, so a winner cannot
    // reload ahead of the losers of its batch.
    always_ff @(posedge clk) begin
        if (rst)
            batch_open <= 1'b1;
        else if (state == IDLE)
            batch_open <= ~|hold_v;
    end

    assign bus.req_ready = ~hold_v & {PORT_NUB{batch_open}};
`else
    assign bus.req_ready = ~hold_v;
`endif

    assign accept  = bus.req_valid & bus.req_ready;
    assign busy    = (state != IDLE);
    assign capture = (state == WAIT) && (cnt == CW'(SORT_LAT));

    // Slot j wins unless an earlier valid slot targets the same dest;
    // all-pairs, so sorter key order does not matter.
    function automatic logic slot_wins(input logic [WT-1:0] v, input int j);
        logic w;
        w = v[j*WP+WP-1];
        for (int k = 0; k < j; k++)
            if (v[k*WP+WP-1] && v[k*WP+DW+AW +: AW] == v[j*WP+DW+AW +: AW])
                w = 1'b0;
        return w;
    endfunction

    always_comb begin
        resolved = sort_out;
        win_src  = '0;
        for (int j = 0; j < PORT_NUB; j++) begin
            if (slot_wins(sort_out, j)) begin
                for (int i = 0; i < PORT_NUB; i++)
                    if (sort_out[j*WP+DW +: AW] == AW'(i))
                        win_src[i] = 1'b1;
            end else begin
                resolved[j*WP+WP-1] = 1'b0;
            end
        end
    end

    always_comb begin
        wave = '0;
        for (int i = 0; i < PORT_NUB; i++)
            if (hold_v[i])
                wave[i*WP +: WP] = {1'b1, hold_dest[i], AW'(i), hold_data[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_v        <= '0;
            sort_in       <= '0;
            bus.out_port  <= '0;
            bus.grant     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|hold_v) begin
                        sort_in <= wave;
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Zeros behind the wave flush the sorter pipeline.
                    sort_in <= '0;
                    if (capture) begin
                        bus.out_port  <= resolved;
                        bus.grant     <= win_src;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            hold_v <= (hold_v & ~(capture ? win_src : {PORT_NUB{1'b0}}))
                    | accept;
            for (int i = 0; i < PORT_NUB; i++) begin
                if (accept[i]) begin
                    hold_dest[i] <= bus.req_dest[i*AW +: AW];
                    hold_data[i] <= bus.req_data[i*DW +: DW];
                end
            end
        end
    end
endmodule

// File: tb/tb_sort_wave_scheduler.sv
// Randomised + directed bench for sort_wave_scheduler against a
// transaction-level reference model of holds, waves and grants.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module tb_sort_wave_scheduler;
    localparam int PN  = 4;
    localparam int LAT = 3;
    localparam int AW  = $clog2(`PORT_NUB_TOTAL);
    localparam int DW  = `DATA_WIDTH;
    localparam int WP  = 1 + 2 * AW + DW;
    localparam int WT  = PN * WP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WT-1:0] sort_in;
    logic [WT-1:0] sort_out;
    logic          busy;

    sort_wave_scheduler_if #(.PORT_NUB(PN), .AW(AW), .DW(DW)) bus ();

    sort_wave_scheduler #(.PORT_NUB(PN), .SORT_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sort_in  (sort_in),
        .sort_out (sort_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Sorter stand-in: LAT-cycle delay, slots ordered by descending word
    // (valid first, then larger dest, then larger src).
    logic [WT-1:0] pipe [LAT] = '{default: '0};

    always @(posedge clk) begin
        pipe[0] <= sort_in;
        for (int k = 1; k < LAT; k++)
            pipe[k] <= pipe[k-1];
    end

    function automatic logic [WT-1:0] sorter(input logic [WT-1:0] v);
        logic [WP-1:0] s [PN];
        logic [WP-1:0] t;
        logic [WT-1:0] r;
        for (int i = 0; i < PN; i++) s[i] = v[i*WP +: WP];
        for (int a = 0; a < PN; a++)
            for (int b = 0; b < PN - 1; b++)
                if (s[b] < s[b+1]) begin
                    t = s[b]; s[b] = s[b+1]; s[b+1] = t;
                end
        for (int i = 0; i < PN; i++) r[i*WP +: WP] = s[i];
        return r;
    endfunction

    assign sort_out = sorter(pipe[LAT-1]);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit            m_hv [PN];
    logic [AW-1:0] m_dest [PN];
    logic [DW-1:0] m_data [PN];
    bit            w_v [PN];
    logic [AW-1:0] w_dest [PN];
    logic [DW-1:0] w_data [PN];
    bit            m_fly, m_ov, m_bopen, m_fresh;
    int            m_age;
    logic [PN-1:0] m_grant;
    logic [WT-1:0] m_sin;

    // Stimulus for the next cycle
    logic [PN-1:0]    tb_v;
    logic [PN*AW-1:0] tb_d;
    logic [PN*DW-1:0] tb_x;
    logic             tb_ordy;
    logic             tb_rst;

    function automatic logic [PN-1:0] exp_ready();
        logic [PN-1:0] r;
        for (int i = 0; i < PN; i++) begin
            r[i] = !m_hv[i];
`ifdef SORT_SCHED_BATCH_EN
            r[i] = r[i] && m_bopen;
`endif
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PN; i++) m_hv[i] = 0;
        m_fly = 0; m_ov = 0; m_bopen = 1; m_fresh = 1;
        m_age = 0; m_grant = '0; m_sin = '0;
    endtask

    task automatic model_step();
        logic [PN-1:0] rdy;
        bit any;
        rdy = exp_ready();
        if (tb_rst) begin
            model_reset();
            return;
        end
        any = 0;
        for (int i = 0; i < PN; i++) any |= m_hv[i];
        m_sin = '0;
        if (!m_fly) begin
            if (any) begin
                for (int i = 0; i < PN; i++) begin
                    w_v[i] = m_hv[i]; w_dest[i] = m_dest[i];
                    w_data[i] = m_data[i];
                    if (m_hv[i])
                        m_sin[i*WP +: WP] = {1'b1, m_dest[i], AW'(i), m_data[i]};
                end
                m_fly = 1; m_age = 0; m_bopen = 0;
            end else begin
                m_bopen = 1;
            end
        end else if (!m_ov) begin
            if (m_age == LAT) begin
                // Among equal dests the bench sorter puts the larger src
                // first, so the highest-numbered requester wins.
                m_grant = '0;
                for (int p = 0; p < PN; p++) begin
                    bit beaten = 0;
                    for (int q = p + 1; q < PN; q++)
                        if (w_v[q] && w_dest[q] == w_dest[p]) beaten = 1;
                    if (w_v[p] && !beaten) begin
                        m_grant[p] = 1'b1;
                        m_hv[p] = 0;
                    end
                end
                m_ov = 1; m_fresh = 0;
            end else begin
                m_age++;
            end
        end else if (tb_ordy) begin
            m_ov = 0; m_fly = 0;
        end
        for (int i = 0; i < PN; i++)
            if (tb_v[i] && rdy[i]) begin
                m_hv[i] = 1;
                m_dest[i] = tb_d[i*AW +: AW];
                m_data[i] = tb_x[i*DW +: DW];
            end
    endtask

    task automatic check_outputs();
        int nv;
        chk("req_ready", bus.req_ready, exp_ready());
        chk("busy", busy, m_fly);
        chk("out_valid", bus.out_valid, m_ov);
        chk("sort_in", sort_in, m_sin);
        if (m_fresh) begin
            chk("rst_out_port", bus.out_port, '0);
            chk("rst_grant", bus.grant, '0);
        end
        if (m_ov) begin
            nv = 0;
            chk("grant", bus.grant, m_grant);
            for (int j = 0; j < PN; j++) begin
                logic [WP-1:0] s;
                int src;
                s = bus.out_port[j*WP +: WP];
                if (s[WP-1]) begin
                    nv++;
                    src = int'(s[DW +: AW]);
                    chk("slot_win", m_grant[src], 1);
                    chk("slot_dest", s[DW+AW +: AW], w_dest[src]);
                    chk("slot_data", s[DW-1:0], w_data[src]);
                end
            end
            chk("n_valid", nv, $countones(m_grant));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        bus.req_valid = tb_v;
        bus.req_dest  = tb_d;
        bus.req_data  = tb_x;
        bus.out_ready = tb_ordy;
        rst           = tb_rst;
        model_step();
    endtask

    task automatic idle_in();
        tb_v = '0; tb_d = '0; tb_x = '0; tb_ordy = 1'b1; tb_rst = 1'b0;
    endtask

    task automatic drain();
        bit pend;
        idle_in();
        for (int n = 0; n < 200; n++) begin
            pend = m_fly;
            for (int i = 0; i < PN; i++) pend |= m_hv[i];
            if (!pend) break;
            cyc();
        end
        cyc();
        cyc();
        chk("drained", {busy, bus.req_ready}, {1'b0, {PN{1'b1}}});
    endtask

    task automatic send(input logic [PN-1:0] v, input logic [PN*AW-1:0] d,
                        input logic [PN*DW-1:0] x);
        tb_v = v; tb_d = d; tb_x = x;
        cyc();
        tb_v = '0;
    endtask

    initial begin
        int n;
        bus.req_valid = '0; bus.req_dest = '0; bus.req_data = '0;
        bus.out_ready = 1'b1;
        model_reset();
        idle_in();
        tb_rst = 1'b1;
        repeat (2) @(posedge clk);
        tb_rst = 1'b0;

        // Single request: port 2 -> dest 1, data A5
        send(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, {8'h00, 8'hA5, 8'h00, 8'h00});
        n = 0;
        while (!bus.out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("lat_single", n, 6);
        chk("grant_single", bus.grant, 4'b0100);
        drain();

        // Full conflict, re-requesting every cycle
        tb_v = 4'hF; tb_d = {4{2'd3}}; tb_x = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (30) cyc();
        drain();

        // Disjoint dests
        send(4'hF, {2'd0, 2'd1, 2'd2, 2'd3}, {8'hD3, 8'hC2, 8'hB1, 8'hA0});
        drain();

        // Retry ordering
        send(4'b1011, {2'd0, 2'd0, 2'd2, 2'd2}, {8'h99, 8'h00, 8'h77, 8'h66});
        drain();

        // Backpressure while new requests arrive
        send(4'b0011, {2'd0, 2'd0, 2'd1, 2'd1}, {8'h00, 8'h00, 8'h5A, 8'h4B});
        while (!bus.out_valid && n < 100) begin
            cyc();
            n++;
        end
        tb_ordy = 1'b0;
        tb_v = 4'hF; tb_d = {2'd1, 2'd2, 2'd3, 2'd0};
        tb_x = {8'h13, 8'h24, 8'h35, 8'h46};
        repeat (10) cyc();
        drain();

        // Reset at cnt==1: accept, issue, cnt0, then reset in cnt1 cycle
        send(4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, {8'h0, 8'h0, 8'h0, 8'hE7});
        cyc();
        cyc();
        tb_rst = 1'b1;
        cyc();
        tb_rst = 1'b0;
        cyc();
        chk("rst_state", {busy, bus.out_valid, bus.grant},
            {1'b0, 1'b0, {PN{1'b0}}});
        send(4'b1000, {2'd3, 2'd0, 2'd0, 2'd0}, {8'h3C, 8'h0, 8'h0, 8'h0});
        drain();

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < PN; i++) begin
                tb_v[i] = ($urandom_range(0, 1) == 1);
                tb_d[i*AW +: AW] = ($urandom_range(0, 1) == 1)
                    ? AW'($urandom_range(0, 1)) : AW'($urandom);
                tb_x[i*DW +: DW] = DW'($urandom);
            end
            tb_ordy = ($urandom_range(0, 3) != 0);
            tb_rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
